// File: rtl/biu_constants_pkg.sv
// Bus interface unit constants shared by the cache and the BIU.
//   biu_size_t : transfer size encoding
//   biu_type_t : burst type encoding (write buffer only issues SINGLE)
//   biu_prot_t : protection attribute vector
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011,
    QWORD = 3'b100
  } biu_size_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } biu_type_t;

  typedef logic [2:0] biu_prot_t;

  localparam biu_prot_t PROT_INSTRUCTION = 3'b001;
  localparam biu_prot_t PROT_PRIVILEGED  = 3'b010;
  localparam biu_prot_t PROT_CACHEABLE   = 3'b100;

endpackage

// File: rtl/riscv_cache_pkg.sv
// Cache-wide types.
//   WBUF_XLEN/WBUF_PLEN : data/address widths the write-buffer entry is built for
//   wbuf_entry_t        : one posted write held in the write buffer
//   wbuf_state_t        : write-buffer drain state
package riscv_cache_pkg;
  import biu_constants_pkg::*;

  localparam int WBUF_XLEN = 32;
  localparam int WBUF_PLEN = WBUF_XLEN;

  typedef struct packed {
    logic [WBUF_PLEN-1:0]   adr;
    biu_size_t              size;
    logic                   lock;
    biu_prot_t              prot;
    logic [WBUF_XLEN/8-1:0] be;
    logic [WBUF_XLEN-1:0]   data;
  } wbuf_entry_t;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_DACK = 1'b1
  } wbuf_state_t;

endpackage

// File: rtl/riscv_cache_wbuf_if.sv
// Write-buffer to BIU bus.
//   master : write buffer side (drives strobe and request fields)
//   slave  : BIU side (drives stb_ack, d_ack, err)
interface riscv_cache_wbuf_if
  import biu_constants_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PLEN = XLEN
) ();

  logic              stb;
  logic              stb_ack;
  logic              d_ack;
  logic              err;
  logic [PLEN-1:0]   adri;
  biu_size_t         size;
  biu_type_t         typ;
  logic              lock;
  biu_prot_t         prot;
  logic              we;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   d;

  modport master (
    output stb, adri, size, typ, lock, prot, we, be, d,
    input  stb_ack, d_ack, err
  );

  modport slave (
    input  stb, adri, size, typ, lock, prot, we, be, d,
    output stb_ack, d_ack, err
  );

endinterface

// File: rtl/riscv_cache_wbuf.sv
// Posted write buffer between the cache tag stage and the BIU.
// Writes are queued in program order and drained one at a time.
//   rst_ni, clk_i         : async active-low reset, clock
//   wreq_i..d_i           : write request and its fields from the tag stage
//   pagefault_i           : request faulted, do not queue it
//   full_o / empty_o      : no free entry / nothing pending and BIU idle
//   chk_adr_i / hazard_o  : read address and word-match against queued writes
//   err_o                 : one-cycle pulse when the BIU reports a write error
//   biu                   : BIU bus (master side)
module riscv_cache_wbuf
  import biu_constants_pkg::*;
  import riscv_cache_pkg::*;
#(
  parameter int XLEN  = WBUF_XLEN,
  parameter int PLEN  = WBUF_PLEN,
  parameter int DEPTH = 4
) (
  input  logic              rst_ni,
  input  logic              clk_i,

  input  logic              wreq_i,
  input  logic [PLEN-1:0]   adr_i,
  input  biu_size_t         size_i,
  input  logic              lock_i,
  input  biu_prot_t         prot_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [XLEN-1:0]   d_i,
  input  logic              pagefault_i,
  output logic              full_o,
  output logic              empty_o,

  input  logic [PLEN-1:0]   chk_adr_i,
  output logic              hazard_o,
  output logic              err_o,

  riscv_cache_wbuf_if.master biu
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int OFFS = $clog2(XLEN/8);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  wbuf_entry_t       mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [AW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     count_q, count_d;
  wbuf_state_t       state_q;
  logic              err_q;

  logic              push, pop, stb;
  wbuf_entry_t       head, entry_in;
  logic [DEPTH-1:0]  hit;
  logic              chk_unused;

  // full_o looks only at the registered count, so a pop in this cycle
  // frees its slot one cycle later.
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0) && (state_q == WB_IDLE);
  assign push    = wreq_i & ~pagefault_i & ~full_o;
  assign stb     = (state_q == WB_IDLE) && (count_q != '0);
  assign pop     = (state_q == WB_WAIT_DACK) && (biu.d_ack || biu.err);
  assign err_o   = err_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    entry_in      = '0;
    entry_in.adr  = adr_i;
    entry_in.size = size_i;
    entry_in.lock = lock_i;
    entry_in.prot = prot_i;
    entry_in.be   = be_i;
    entry_in.data = d_i;
  end

  // Control state, pointers, valid vector and the error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WB_IDLE;
      count_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      count_q <= count_d;

      case (state_q)
        WB_IDLE: begin
          if (stb && biu.stb_ack) state_q <= WB_WAIT_DACK;
        end
        WB_WAIT_DACK: begin
          // An error retires the write just like d_ack; it is not retried.
          if (biu.d_ack || biu.err) begin
            state_q <= WB_IDLE;
            err_q   <= biu.err;
          end
        end
        default: state_q <= WB_IDLE;
      endcase

      // push and pop never hit the same slot: a pop needs count>0 and a
      // push needs count<DEPTH, so wp!=rp whenever both happen.
      if (pop) begin
        rp_q          <= rp_q + PTR_ONE;
        valid_q[rp_q] <= 1'b0;
      end
      if (push) begin
        wp_q          <= wp_q + PTR_ONE;
        valid_q[wp_q] <= 1'b1;
      end
    end
  end

  // Entry storage carries no reset; valid_q qualifies every read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wp_q] <= entry_in;
  end

  assign head = mem_q[rp_q];

  // Head fields come straight from storage so they stay stable while the
  // entry waits for stb_ack and then d_ack/err.
  assign biu.stb  = stb;
  assign biu.adri = head.adr;
  assign biu.size = head.size;
  assign biu.typ  = SINGLE;
  assign biu.lock = head.lock;
  assign biu.prot = head.prot;
  assign biu.we   = 1'b1;
  assign biu.be   = head.be;
  assign biu.d    = head.data;

  // Word-granular read-after-write check against every queued write,
  // including the one currently in flight.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
      assign hit[gi] = valid_q[gi] &&
                       (mem_q[gi].adr[PLEN-1:OFFS] == chk_adr_i[PLEN-1:OFFS]);
    end
  endgenerate

  assign hazard_o   = |hit;
  assign chk_unused = ^chk_adr_i[OFFS-1:0];

endmodule

// File: tb/tb_riscv_cache_wbuf.sv
module tb_riscv_cache_wbuf;
  import biu_constants_pkg::*;

  localparam int XLEN  = 32;
  localparam int PLEN  = 32;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wreq_i, lock_i, pagefault_i;
  logic [31:0] adr_i, d_i, chk_adr_i;
  biu_size_t   size_i;
  biu_prot_t   prot_i;
  logic [3:0]  be_i;
  logic        full_o, empty_o, hazard_o, err_o;

  always #5 clk_i = ~clk_i;

  riscv_cache_wbuf_if #(.XLEN(XLEN), .PLEN(PLEN)) biu ();

  riscv_cache_wbuf #(.XLEN(XLEN), .PLEN(PLEN), .DEPTH(DEPTH)) dut (
    .rst_ni      (rst_ni),
    .clk_i       (clk_i),
    .wreq_i      (wreq_i),
    .adr_i       (adr_i),
    .size_i      (size_i),
    .lock_i      (lock_i),
    .prot_i      (prot_i),
    .be_i        (be_i),
    .d_i         (d_i),
    .pagefault_i (pagefault_i),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .chk_adr_i   (chk_adr_i),
    .hazard_o    (hazard_o),
    .err_o       (err_o),
    .biu         (biu)
  );

  // Reference model: an ordered list of queued writes, a flag saying the
  // oldest one has been accepted by the BIU, and the expected error pulse.
  typedef struct {
    logic [31:0] adr;
    biu_size_t   size;
    logic        lock;
    biu_prot_t   prot;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   inflight;
  bit   err_exp;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_hazard(input logic [31:0] a);
    foreach (q[i]) if (q[i].adr[31:2] == a[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    inflight = 1'b0;
    err_exp  = 1'b0;
  endtask

  // One clock: compare every output against the model mid-cycle, then
  // advance the model with the inputs that were applied at the edge.
  task automatic step();
    bit   exp_stb, exp_full, take, done, perr, do_push;
    ent_t e;
    @(negedge clk_i);
    exp_stb  = !inflight && (q.size() > 0);
    exp_full = (q.size() == DEPTH);
    check("stb",    64'(biu.stb), 64'(exp_stb));
    check("full",   64'(full_o), 64'(exp_full));
    check("empty",  64'(empty_o), 64'((q.size() == 0) && !inflight));
    check("hazard", 64'(hazard_o), 64'(model_hazard(chk_adr_i)));
    check("err",    64'(err_o), 64'(err_exp));
    check("we",     64'(biu.we), 64'(1));
    check("type",   64'(biu.typ), 64'(SINGLE));
    if (q.size() > 0) begin
      check("adri", 64'(biu.adri), 64'(q[0].adr));
      check("size", 64'(biu.size), 64'(q[0].size));
      check("lock", 64'(biu.lock), 64'(q[0].lock));
      check("prot", 64'(biu.prot), 64'(q[0].prot));
      check("be",   64'(biu.be), 64'(q[0].be));
      check("d",    64'(biu.d), 64'(q[0].d));
    end
    take    = exp_stb && biu.stb_ack;
    done    = inflight && (biu.d_ack || biu.err);
    perr    = inflight && biu.err;
    do_push = wreq_i && !pagefault_i && !exp_full;
    e = '{adr_i, size_i, lock_i, prot_i, be_i, d_i};
    @(posedge clk_i);
    #1;
    if (take) inflight = 1'b1;
    if (done) begin
      void'(q.pop_front());
      inflight = 1'b0;
    end
    err_exp = perr;
    if (do_push) q.push_back(e);
  endtask

  task automatic idle_in();
    wreq_i      = 1'b0;
    pagefault_i = 1'b0;
    biu.stb_ack = 1'b0;
    biu.d_ack   = 1'b0;
    biu.err     = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    wreq_i = 1'b1;
    adr_i  = a;
    be_i   = b;
    d_i    = d;
    size_i = WORD;
    lock_i = 1'b0;
    prot_i = PROT_PRIVILEGED;
    step();
    wreq_i = 1'b0;
  endtask

  task automatic ack_head();
    biu.stb_ack = 1'b1; step(); biu.stb_ack = 1'b0;
    biu.d_ack   = 1'b1; step(); biu.d_ack   = 1'b0;
  endtask

  initial begin
    idle_in();
    adr_i = '0; d_i = '0; be_i = '0; chk_adr_i = '0;
    size_i = WORD; lock_i = 1'b0; prot_i = '0;
    model_reset();

    // Reset values while held in reset.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_stb",   64'(biu.stb), 64'(0));
    check("rst_empty", 64'(empty_o), 64'(1));
    check("rst_full",  64'(full_o), 64'(0));
    check("rst_err",   64'(err_o), 64'(0));
    check("rst_haz",   64'(hazard_o), 64'(0));
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Reset asserted while a write is being strobed discards it.
    push(32'h0000_0080, 4'hF, 32'h1111_2222);
    check("pre_rst_stb", 64'(biu.stb), 64'(1));
    chk_adr_i = 32'h0000_0080;
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_stb",   64'(biu.stb), 64'(0));
    check("mid_rst_empty", 64'(empty_o), 64'(1));
    check("mid_rst_haz",   64'(hazard_o), 64'(0));
    model_reset();
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single write, strobe one cycle after the push edge.
    push(32'h0000_0100, 4'hF, 32'hDEAD_BEEF);
    check("sw_stb",  64'(biu.stb), 64'(1));
    check("sw_adr",  64'(biu.adri), 64'(32'h100));
    check("sw_d",    64'(biu.d), 64'(32'hDEAD_BEEF));
    check("sw_be",   64'(biu.be), 64'(4'hF));
    biu.stb_ack = 1'b1; step(); biu.stb_ack = 1'b0;
    check("sw_wait_stb", 64'(biu.stb), 64'(0));
    step(); step();
    biu.d_ack = 1'b1; step(); biu.d_ack = 1'b0;
    check("sw_empty", 64'(empty_o), 64'(1));

    // Fill to DEPTH, overflow push ignored, drain in order.
    for (int i = 0; i < DEPTH; i++) push(32'h200 + 32'(4*i), 4'hF, 32'hA0 + 32'(i));
    check("fill_full", 64'(full_o), 64'(1));
    push(32'h300, 4'h3, 32'hBAD0_BAD0);
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_order", 64'(biu.d), 64'(32'hA0 + 32'(i)));
      ack_head();
    end
    check("fill_empty", 64'(empty_o), 64'(1));

    // Hazard on word match, cleared once the write retires.
    push(32'h104, 4'h1, 32'h55);
    chk_adr_i = 32'h106; #1;
    check("haz_hit", 64'(hazard_o), 64'(1));
    chk_adr_i = 32'h108; #1;
    check("haz_miss", 64'(hazard_o), 64'(0));
    chk_adr_i = 32'h106;
    ack_head();
    check("haz_gone", 64'(hazard_o), 64'(0));

    // BIU error: one-cycle pulse, entry dropped, next entry strobed.
    push(32'h400, 4'hF, 32'h4);
    push(32'h500, 4'hF, 32'h5);
    biu.stb_ack = 1'b1; step(); biu.stb_ack = 1'b0;
    biu.err = 1'b1; step(); biu.err = 1'b0;
    check("err_pulse", 64'(err_o), 64'(1));
    check("err_next",  64'(biu.adri), 64'(32'h500));
    check("err_stb",   64'(biu.stb), 64'(1));
    step();
    check("err_once",  64'(err_o), 64'(0));
    ack_head();

    // Push and pop in the same cycle at two entries.
    push(32'h600, 4'hF, 32'h6);
    push(32'h700, 4'hF, 32'h7);
    biu.stb_ack = 1'b1; step(); biu.stb_ack = 1'b0;
    biu.d_ack = 1'b1; wreq_i = 1'b1; adr_i = 32'h800; d_i = 32'h8;
    step();
    biu.d_ack = 1'b0; wreq_i = 1'b0;
    check("pp_stb",  64'(biu.stb), 64'(1));
    check("pp_head", 64'(biu.adri), 64'(32'h700));
    check("pp_full", 64'(full_o), 64'(0));
    ack_head();
    ack_head();

    // Faulted request never enters the buffer.
    wreq_i = 1'b1; pagefault_i = 1'b1; adr_i = 32'h900;
    step();
    idle_in();
    check("pf_empty", 64'(empty_o), 64'(1));

    // Random traffic with a randomly behaving BIU.
    for (int n = 0; n < 3000; n++) begin
      wreq_i      = ($urandom % 2) == 0;
      pagefault_i = ($urandom % 8) == 0;
      adr_i       = 32'h1000 | 32'($urandom_range(0, 7) << 2) | 32'($urandom % 4);
      chk_adr_i   = 32'h1000 | 32'($urandom_range(0, 7) << 2) | 32'($urandom % 4);
      d_i         = $urandom;
      be_i        = 4'($urandom);
      lock_i      = 1'($urandom);
      prot_i      = biu_prot_t'($urandom);
      case ($urandom % 3)
        0:       size_i = BYTE;
        1:       size_i = HWORD;
        default: size_i = WORD;
      endcase
      biu.stb_ack = ($urandom % 5) < 2;
      biu.d_ack   = ($urandom % 10) < 3;
      biu.err     = ($urandom % 10) == 0;
      step();
    end

    // Drain with a bounded number of cycles.
    idle_in();
    for (int n = 0; n < 200 && (q.size() > 0 || inflight); n++) begin
      biu.stb_ack = ($urandom % 2) == 0;
      biu.d_ack   = ($urandom % 2) == 0;
      step();
    end
    idle_in();
    step();
    check("drain_done", 64'(empty_o), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
